// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator readout path: accumulator state
// encoding and the default window constants that must agree with the
// comparator phase generator's timing.
`timescale 1ns/1ps

package cmp_pkg;

    // Accumulator control states.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    // Decisions per window and majority threshold used by default.
    localparam int DEFAULT_WINDOW      = 64;
    localparam int DEFAULT_MAJ_THRESH  = 32;

    // Depth of the comparator output synchronizer.
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Nominal spacing, in clocks, between sample strobes from the phase
    // generator. The synchronizer depth must stay below this so a fresh
    // decision has settled before it is strobed.
    localparam int PHASE_SAMPLE_SPACING = 4;

    // Width needed to hold a ones count of 0..window inclusive.
    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/cmp_sync.sv
// Generic multi-flop synchronizer for a single asynchronous bit. Used on
// the comparator latch output and on other analog-to-digital crossings.
`timescale 1ns/1ps

module cmp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw input through the flop chain; the oldest stage is the
    // synchronized value, so a change appears SYNC_STAGES edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cmp_decision_acc.sv
// Comparator decision accumulator. Synchronizes the comparator output,
// counts ones over back-to-back windows of WINDOW decisions and offers
// each window's count, with a majority flag, over a valid/ready handshake.
// A window that completes while an earlier result is still unconsumed is
// dropped and reported with a one-cycle overflow pulse.
`timescale 1ns/1ps

module cmp_decision_acc
    import cmp_pkg::*;
#(
    parameter  int WINDOW      = DEFAULT_WINDOW,
    parameter  int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter  int MAJ_THRESH  = DEFAULT_MAJ_THRESH,
    localparam int CNT_W       = cnt_width(WINDOW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmp_out,
    input  logic             sample,
    input  logic             enable,
    output logic [CNT_W-1:0] count_o,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             majority_o,
    output logic             overflow,
    output logic             busy
);

    // The decision index only needs to reach WINDOW-1 before it is cleared.
    localparam int N_W = $clog2(WINDOW);

    localparam logic [N_W-1:0]   N_LAST = N_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(MAJ_THRESH);

    acc_state_t       state;
    logic [N_W-1:0]   n;
    logic [CNT_W-1:0] ones;

    logic             d_sync;
    logic             sample_take;
    logic             window_done;
    logic             result_load;
    logic             result_drop;
    logic             transfer;
    logic [CNT_W-1:0] result;

    cmp_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(cmp_out),
        .sync_out(d_sync)
    );

    // Decode which strobes count, when a window closes, and whether its
    // result can be stored or must be dropped. A strobe in the cycle where
    // enable falls is not taken, and IDLE never takes strobes, which also
    // covers the cycle where enable rises.
    always_comb begin
        sample_take = 1'b0;
        window_done = 1'b0;
        result_load = 1'b0;
        result_drop = 1'b0;
        transfer    = count_valid && count_ready;
        result      = ones + CNT_W'(d_sync);

        if (state == ACCUM && enable && sample) begin
            sample_take = 1'b1;
            if (n == N_LAST) begin
                window_done = 1'b1;
            end
        end

        if (window_done) begin
            if (!count_valid || count_ready) begin
                result_load = 1'b1;
            end else begin
                result_drop = 1'b1;
            end
        end
    end

    // Control FSM and window counters. Windows run back-to-back: the
    // completing strobe clears the counters without leaving ACCUM. Leaving
    // ACCUM throws away any partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            n     <= '0;
            ones  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    n    <= '0;
                    ones <= '0;
                    if (enable) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                    end
                end

                ACCUM: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        n     <= '0;
                        ones  <= '0;
                    end else if (window_done) begin
                        n    <= '0;
                        ones <= '0;
                    end else if (sample_take) begin
                        n    <= n + 1'b1;
                        ones <= result;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    n     <= '0;
                    ones  <= '0;
                end
            endcase
        end
    end

    // Result register and handshake. A load may coincide with a transfer of
    // the previous result, in which case valid simply stays high. count_o
    // only changes on a load, so it is stable while a result is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_o     <= '0;
            majority_o  <= 1'b0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            overflow <= result_drop;
            if (result_load) begin
                count_o     <= result;
                majority_o  <= (result >= THRESH);
                count_valid <= 1'b1;
            end else if (transfer) begin
                count_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cmp_decision_acc.md
Name: cmp_decision_acc

Overview:
- Downstream consumer of the comparator clock-phase generator.
- Captures the comparator's digital decision on each sample strobe and counts ones over a fixed window of decisions (duty / first-order decimation).
- Presents each window result through a valid/ready handshake with a majority flag.
- Feeds the calibration/readout logic that interprets comparator statistics.

Parameters:
- WINDOW, 64, decisions per result window; legal range 2..1024.
- SYNC_STAGES, 2, synchronizer depth on cmp_out; minimum 2.
- MAJ_THRESH, 32, majority_o=1 when a window count is >= this value; legal range 0..WINDOW.
- Derived localparam CNT_W = $clog2(WINDOW+1); 7 for the defaults.

Ports:
- clk  input  1  system clock; same clock as the phase generator.
- rst_n  input  1  asynchronous, active-low reset.
- cmp_out  input  1  comparator latch output; asynchronous to clk.
- sample  input  1  one-cycle decision strobe from the phase generator.
- enable  input  1  run accumulation; level-sensitive.
- count_o  output  CNT_W  ones count of the last completed window.
- count_valid  output  1  count_o/majority_o hold an unconsumed result.
- count_ready  input  1  consumer accepts the result.
- majority_o  output  1  (count_o >= MAJ_THRESH); updates with count_o.
- overflow  output  1  one-cycle pulse: a window completed and its result was dropped.
- busy  output  1  high while in ACCUM.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; all counters, count_o, count_valid, majority_o, overflow and busy = 0; synchronizer flops = 0.
- Synchronizer:
  - cmp_out passes through SYNC_STAGES flops to give d_sync.
  - A cmp_out change is visible in d_sync SYNC_STAGES rising edges later.
  - The decision is d_sync in any cycle where sample=1.
- sample is level-per-cycle, with no edge detect:
  - Every cycle with sample=1 is one decision.
  - Back-to-back strobes are legal.
  - Nominal upstream spacing is 4 clocks.
- FSM states:
  - IDLE: busy=0; counters held at 0. If enable=1, go to ACCUM next cycle. A sample in the same cycle enable rises is ignored.
  - ACCUM: busy=1. On sample: ones += d_sync, n += 1.
- Window completion: the cycle with sample=1 and n==WINDOW-1.
  - Result R = ones + d_sync.
  - n and ones clear to 0; the FSM stays in ACCUM, so windows run back-to-back with no lost samples.
- Result register: on completion, R is loaded into count_o next cycle, majority_o=(R>=MAJ_THRESH) and count_valid=1, if either:
  - count_valid==0, or
  - count_valid==1 and count_ready==1 in that same cycle (transfer plus reload; valid stays 1, no overflow).
- Dropped result: if count_valid==1 and count_ready==0 at completion, R is discarded, count_o is unchanged, and overflow pulses for 1 cycle (registered, the cycle after completion).
- Handshake:
  - Transfer occurs when count_valid && count_ready.
  - count_valid falls the next cycle unless a reload happens.
  - count_o is stable while count_valid=1.
  - count_ready with count_valid=0 has no effect.
- Latency: count_valid rises 1 cycle after the final sample of a window.
- Counter widths:
  - ones is CNT_W bits and never exceeds WINDOW, so no wrap.
  - n is $clog2(WINDOW) bits and wraps only through explicit clear.
- enable deassert in ACCUM:
  - Next cycle goes to IDLE; the partial window is discarded (n, ones cleared).
  - A sample in that same cycle is ignored.
  - A pending result stays valid until consumed.
- Reset mid-operation: immediate clear of everything; a pending result is lost.
- WINDOW=2 edge case: completion on every second strobe; must work.

Decomposition:
- Shared package cmp_pkg holds:
  - typedef enum logic {IDLE, ACCUM} acc_state_t;
  - default WINDOW/MAJ_THRESH constants shared with the phase generator's timing constants.
- One sub-module, cmp_sync: parameterized SYNC_STAGES flop chain with async active-low reset. It is reused for other analog-to-digital crossings.

Test Plan:
- cmp_out=1 constant, enable=1, count_ready=1, 64 strobes every 4 clks -> one result: count_o=64, majority_o=1, count_valid high exactly 1 cycle, 1 cycle after the 64th strobe.
- cmp_out toggled so decisions alternate 1,0,... -> count_o=32, majority_o=1; shift the pattern so 31 ones -> count_o=31, majority_o=0.
- count_ready=0 for two full windows (cmp_out=1, then 0) -> count_o holds 64 through the second completion, overflow pulses once; raising count_ready then transfers 64 and count_valid drops.
- count_ready asserted exactly in the completion cycle of window 2 (results 64, 0) -> no overflow; count_o=0 and count_valid stays 1 continuously.
- enable dropped after 10 strobes with cmp_out=1, re-enabled, then 64 strobes with cmp_out=0 -> count_o=0 (partial window discarded); busy follows the state.
- rst_n pulsed low mid-window with count_valid=1 -> all outputs 0 asynchronously. Also step cmp_out 0->1 -> a strobe 1 cycle after the edge is counted 0, and a strobe SYNC_STAGES cycles after the edge is counted 1.
